// File: rtl/pe_noc_endpoint.sv
// PE-side NoC endpoint: packs local payloads into {dest, payload} flits through a TX FIFO,
// strips inbound flits through a 2-entry skid buffer. Traffic counters built only with PE_NI_STATS_EN.
module pe_noc_endpoint #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 2,
    parameter int MyAddr    = 0,
    parameter int TxDepth   = 4
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [DataWidth-1:0]           i_tx_data,
    input  logic [AddrWidth-1:0]           i_tx_dest,
    input  logic                           i_tx_valid,
    output logic                           o_tx_ready,
    output logic [DataWidth+AddrWidth-1:0] o_noc_data,
    output logic                           o_noc_data_valid,
    input  logic                           i_noc_data_ready,
    input  logic [DataWidth+AddrWidth-1:0] i_noc_data,
    input  logic                           i_noc_data_valid,
    output logic                           o_noc_data_ready,
    output logic [DataWidth-1:0]           o_rx_data,
    output logic                           o_rx_valid,
    input  logic                           i_rx_ready,
    output logic                           o_misroute,
    output logic [15:0]                    o_tx_count,
    output logic [15:0]                    o_rx_count
);

    localparam int FlitW = DataWidth + AddrWidth;
    localparam int PtrW  = $clog2(TxDepth);
    localparam int CntW  = PtrW + 1;

    // ---------------- TX path ----------------
    logic [FlitW-1:0] tx_mem_q [TxDepth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  tx_cnt_q, tx_cnt_d, tx_left;
    logic [FlitW-1:0] tx_head_q, tx_head_d;
    logic             tx_ready_q, tx_valid_q;
    logic             tx_push, tx_pop;

    assign tx_push = i_tx_valid & tx_ready_q;
    assign tx_pop  = tx_valid_q & i_noc_data_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PtrW'(tx_push);
        rd_ptr_d = rd_ptr_q + PtrW'(tx_pop);
        tx_left  = tx_cnt_q - CntW'(tx_pop);
        tx_cnt_d = tx_left + CntW'(tx_push);
        // Bypass the memory when the pushed flit becomes the head in the same cycle.
        if (tx_left == '0) tx_head_d = {i_tx_dest, i_tx_data};
        else               tx_head_d = tx_mem_q[rd_ptr_d];
    end

    // NOTE: storage array has no reset; pointers and count define which entries are live.
    always_ff @(posedge i_clk) begin
        if (tx_push) tx_mem_q[wr_ptr_q] <= {i_tx_dest, i_tx_data};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tx_cnt_q   <= '0;
            tx_head_q  <= '0;
            tx_ready_q <= 1'b0;
            tx_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_head_q  <= tx_head_d;
            // NOTE: flags are registered from next-state count so they match the FIFO every cycle.
            tx_ready_q <= (tx_cnt_d != CntW'(TxDepth));
            tx_valid_q <= (tx_cnt_d != '0);
        end
    end

    assign o_tx_ready       = tx_ready_q;
    assign o_noc_data_valid = tx_valid_q;
    assign o_noc_data       = tx_head_q;

    // ---------------- RX path ----------------
    logic [DataWidth-1:0] rx_head_q, rx_head_d, rx_tail_q, rx_tail_d;
    logic [1:0]           rx_cnt_q, rx_cnt_d, rx_left;
    logic                 rx_ready_q, misroute_q;
    logic                 rx_accept, rx_deliver;

    assign rx_accept  = i_noc_data_valid & rx_ready_q;
    assign rx_deliver = (rx_cnt_q != 2'd0) & i_rx_ready;

    always_comb begin
        rx_head_d = rx_head_q;
        rx_tail_d = rx_tail_q;
        if (rx_deliver) rx_head_d = rx_tail_q;
        rx_left = rx_cnt_q - 2'(rx_deliver);
        if (rx_accept) begin
            if (rx_left == 2'd0) rx_head_d = i_noc_data[DataWidth-1:0];
            else                 rx_tail_d = i_noc_data[DataWidth-1:0];
        end
        rx_cnt_d = rx_left + 2'(rx_accept);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_head_q  <= '0;
            rx_tail_q  <= '0;
            rx_cnt_q   <= '0;
            rx_ready_q <= 1'b0;
            misroute_q <= 1'b0;
        end else begin
            rx_head_q  <= rx_head_d;
            rx_tail_q  <= rx_tail_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_ready_q <= (rx_cnt_d < 2'd2);
            if (rx_accept && (i_noc_data[FlitW-1:DataWidth] != AddrWidth'(MyAddr)))
                misroute_q <= 1'b1;
        end
    end

    assign o_noc_data_ready = rx_ready_q;
    assign o_rx_valid       = (rx_cnt_q != 2'd0);
    assign o_rx_data        = rx_head_q;
    assign o_misroute       = misroute_q;

    // ---------------- Statistics ----------------
`ifdef PE_NI_STATS_EN
    logic [15:0] tx_count_q, rx_count_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tx_count_q <= '0;
            rx_count_q <= '0;
        end else begin
            if (tx_pop)    tx_count_q <= tx_count_q + 16'd1;
            if (rx_accept) rx_count_q <= rx_count_q + 16'd1;
        end
    end

    assign o_tx_count = tx_count_q;
    assign o_rx_count = rx_count_q;
`else
    assign o_tx_count = '0;
    assign o_rx_count = '0;
`endif

endmodule

// File: doc/pe_noc_endpoint.md
Name: pe_noc_endpoint

Overview:
PE-side network interface for the HNoC fabric; it is the opposite end of each PE port of the NoC top.
- Accepts local payloads plus a destination PE index, packs them into flits and drives them into the NoC inject port.
- Accepts flits from the NoC eject port and strips the address to deliver the payload to the PE.
- Buffers both directions and keeps traffic statistics.
- One instance sits beside each PE, in that PE's clock domain.

Parameters:
DataWidth, 32, payload width in bits
AddrWidth, 2, destination field width; numPE = 2**AddrWidth
MyAddr, 0, this PE's index; used for the misroute check
TxDepth, 4, TX FIFO depth; power of 2, minimum 2

Ports:
i_clk  input  1  block clock
i_reset  input  1  synchronous, active-high reset
i_tx_data  input  DataWidth  local payload to send
i_tx_dest  input  AddrWidth  destination PE index
i_tx_valid  input  1  local send request
o_tx_ready  output  1  TX FIFO can accept a payload
o_noc_data  output  DataWidth+AddrWidth  flit to NoC; connects to i_pe_dataN
o_noc_data_valid  output  1  flit valid; connects to i_pe_data_validN
i_noc_data_ready  input  1  NoC accepts the flit; from o_pe_data_readyN
i_noc_data  input  DataWidth+AddrWidth  flit from NoC; from o_pe_dataN
i_noc_data_valid  input  1  inbound flit valid
o_noc_data_ready  output  1  endpoint accepts the inbound flit
o_rx_data  output  DataWidth  received payload
o_rx_valid  output  1  received payload valid
i_rx_ready  input  1  PE consumes the payload
o_misroute  output  1  sticky: an inbound flit carried an address other than MyAddr
o_tx_count  output  16  flits accepted by the NoC
o_rx_count  output  16  flits accepted from the NoC

Behaviour:
- Clocking and reset:
  - All state is on the rising edge of i_clk. Reset is synchronous and active-high.
  - Reset values: o_tx_ready=0 while i_reset=1 and 1 on the first cycle after release; o_noc_data_valid=0; o_noc_data_ready=0 while i_reset=1 and 1 after release; o_rx_valid=0; o_misroute=0; both counters=0; o_noc_data and o_rx_data=0.
  - Reset mid-operation flushes both buffers. In-flight flits are lost; no partial handshake completes during the reset cycle.
- Flit format: {dest[AddrWidth-1:0], payload[DataWidth-1:0]}, with the address in the MSBs.
- TX path:
  - TxDepth-entry circular FIFO with separate read/write pointers and an occupancy count of width log2(TxDepth)+1.
  - o_tx_ready = !full.
  - Push on i_tx_valid & o_tx_ready. At full, a push is refused even if a pop occurs in the same cycle.
  - o_noc_data_valid = !empty, driven from registers.
  - A push at cycle N is visible on o_noc_data at N+1 when the FIFO was empty; this is 1-cycle latency.
  - Pop on o_noc_data_valid & i_noc_data_ready.
  - While valid is high and ready is low, o_noc_data stays stable and valid stays high.
  - Simultaneous push and pop (not full) leaves the count unchanged.
  - Pointers wrap modulo TxDepth.
  - dest==MyAddr is sent to the NoC unchanged; there is no local loopback.
- RX path:
  - 2-entry skid buffer. o_noc_data_ready = (entries < 2), registered.
  - Accept on i_noc_data_valid & o_noc_data_ready.
  - o_rx_valid = (entries > 0). o_rx_data = payload bits of the head entry.
  - Delivery on o_rx_valid & i_rx_ready.
  - Accept and deliver in the same cycle keeps the entry count unchanged.
  - When 2 entries are held, ready drops the next cycle. No flit is dropped.
  - Flits are delivered in arrival order.
  - Accept-to-o_rx_valid latency is 1 cycle.
- Misroute:
  - On an accepted flit whose address field != MyAddr, o_misroute is set the next cycle and holds until reset.
  - The payload is still delivered.

Optional Feature:
PE_NI_STATS_EN
- Defined:
  - o_tx_count increments on each TX NoC handshake.
  - o_rx_count increments on each RX NoC handshake.
  - Both are 16-bit and wrap 0xFFFF->0x0000. They are cleared only by reset.
- Undefined:
  - Counter registers are not built; o_tx_count and o_rx_count are tied to 0.
  - All other behaviour is identical.

Test Plan:
1. Reset, MyAddr=1: send payload 0xDEADBEEF dest=2, i_noc_data_ready=1 -> o_noc_data=0x2DEADBEEF with valid for exactly 1 cycle, starting 1 cycle after the push; o_tx_count=1.
2. Backpressure: i_noc_data_ready=0, push 5 payloads 0x1..0x5 -> first 4 accepted, o_tx_ready=0 after the 4th; o_noc_data holds 0x1 stable. Raise ready -> flits 0x1..0x4 emerge in order on consecutive cycles; o_tx_ready returns to 1 the cycle after the first pop.
3. RX: inject flits {1,0xA5A5A5A5} and {1,0x5A5A5A5A} back-to-back with i_rx_ready=0 -> both accepted, o_noc_data_ready=0; o_rx_data=0xA5A5A5A5. Release ready -> 0x5A5A5A5A follows; o_misroute=0; o_rx_count=2.
4. Misroute: inject {3,0x12345678} into MyAddr=1 -> payload delivered, o_misroute=1 and stays 1 across 10 further correct flits until i_reset.
5. Reset mid-traffic: TX FIFO holds 3 entries and RX holds 1; assert i_reset for 1 cycle -> all valids 0, counters 0, o_misroute 0; a new push afterwards emerges as the only flit.
6. With PE_NI_STATS_EN: 65537 TX handshakes -> o_tx_count=1. Without the macro -> both counters read 0 throughout.
